// File: rtl/compress_pack_ctrl.sv
// Per-line sequencer for the compressed-bit packing datapath: accumulates chunk
// lengths, schedules Reg1->Reg2 word stores, pads the tail word and presents the line.
module compress_pack_ctrl #(
    parameter int CACHE_LINE      = 128,
    parameter int WORD_SIZE       = 64,
    parameter int CHUNKS_PER_LINE = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_len_valid,
    input  logic [6:0] i_total_length,
    input  logic       i_last,
    input  logic       i_out_ready,
    output logic       o_len_ready,
    output logic       o_store_en,
    output logic [7:0] o_shift_amount,
    output logic       o_pad_en,
    output logic       o_line_valid,
    output logic       o_bypass,
    output logic [8:0] o_line_bits,
    output logic [1:0] o_word_count,
    output logic       o_len_err,
    output logic       o_busy
);

    localparam int CNT_W = (CHUNKS_PER_LINE > 1) ? $clog2(CHUNKS_PER_LINE) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS_PER_LINE - 1);
    localparam logic [7:0]       WORD_8     = 8'(WORD_SIZE);
    localparam logic [8:0]       LINE_9     = 9'(CACHE_LINE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_FLUSH,
        S_DRAIN,
        S_OUTPUT
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       partial_q;
    logic [8:0]       total_q;
    logic [CNT_W-1:0] chunk_cnt_q;
    logic [1:0]       word_count_q;
    logic             bypass_q;

    logic       len_ready;
    logic       hs;
    logic       end_chunk;
    logic [7:0] pn;
    logic [8:0] tn;
    logic       len_bad;
    logic       overflow;
    logic       do_store;
    logic [7:0] partial_nx;

    assign len_ready  = (state_q == S_ACCUM) || (state_q == S_DRAIN);
    assign hs         = i_len_valid & len_ready;
    assign end_chunk  = i_last | (chunk_cnt_q == LAST_CHUNK);
    assign pn         = partial_q + {1'b0, i_total_length};
    assign tn         = total_q + {2'b00, i_total_length};
    assign len_bad    = {1'b0, i_total_length} > WORD_8;
    // An illegal length poisons the line exactly like a budget overflow.
    assign overflow   = len_bad | (tn > LINE_9);
    assign do_store   = !overflow && (pn >= WORD_8);
    assign partial_nx = do_store ? (pn - WORD_8) : pn;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (i_start) state_d = S_ACCUM;
            S_ACCUM: begin
                if (hs) begin
                    if (overflow)        state_d = end_chunk ? S_OUTPUT : S_DRAIN;
                    else if (end_chunk)  state_d = (partial_nx != 8'd0) ? S_FLUSH : S_OUTPUT;
                end
            end
            S_FLUSH:  state_d = S_OUTPUT;
            S_DRAIN:  if (hs && end_chunk) state_d = S_OUTPUT;
            S_OUTPUT: if (i_out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_len_ready    = len_ready;
        o_store_en     = 1'b0;
        o_shift_amount = 8'd0;
        o_pad_en       = 1'b0;
        o_line_valid   = 1'b0;
        o_bypass       = 1'b0;
        o_line_bits    = 9'd0;
        o_len_err      = 1'b0;
        o_word_count   = word_count_q;
        o_busy         = (state_q != S_IDLE);
        unique case (state_q)
            S_ACCUM: begin
                o_len_err = hs & len_bad;
                if (hs && do_store) begin
                    o_store_en     = 1'b1;
                    o_shift_amount = pn;
                end
            end
            S_FLUSH: begin
                o_store_en     = 1'b1;
                o_pad_en       = 1'b1;
                o_shift_amount = WORD_8 - partial_q;
            end
            S_DRAIN:  o_len_err = hs & len_bad;
            S_OUTPUT: begin
                o_line_valid = 1'b1;
                o_bypass     = bypass_q;
                o_line_bits  = bypass_q ? 9'd0 : total_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            partial_q    <= 8'd0;
            total_q      <= 9'd0;
            chunk_cnt_q  <= '0;
            word_count_q <= 2'd0;
            bypass_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        partial_q    <= 8'd0;
                        total_q      <= 9'd0;
                        chunk_cnt_q  <= '0;
                        word_count_q <= 2'd0;
                        bypass_q     <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (hs) begin
                        chunk_cnt_q <= chunk_cnt_q + CNT_W'(1);
                        if (overflow) begin
                            bypass_q <= 1'b1;
                        end else begin
                            partial_q <= partial_nx;
                            total_q   <= tn;
                            if (do_store) word_count_q <= word_count_q + 2'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    partial_q    <= 8'd0;
                    word_count_q <= word_count_q + 2'd1;
                end
                S_DRAIN: if (hs) chunk_cnt_q <= chunk_cnt_q + CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_compress_pack_ctrl.sv
// Scoreboard bench for compress_pack_ctrl: directed lines push expected store,
// error and line events; a negedge monitor pops and compares them.
module tb_compress_pack_ctrl;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_start;
    logic       i_len_valid;
    logic [6:0] i_total_length;
    logic       i_last;
    logic       i_out_ready;
    logic       o_len_ready;
    logic       o_store_en;
    logic [7:0] o_shift_amount;
    logic       o_pad_en;
    logic       o_line_valid;
    logic       o_bypass;
    logic [8:0] o_line_bits;
    logic [1:0] o_word_count;
    logic       o_len_err;
    logic       o_busy;

    compress_pack_ctrl #(
        .CACHE_LINE(128), .WORD_SIZE(64), .CHUNKS_PER_LINE(8)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .i_len_valid(i_len_valid), .i_total_length(i_total_length),
        .i_last(i_last), .i_out_ready(i_out_ready),
        .o_len_ready(o_len_ready), .o_store_en(o_store_en),
        .o_shift_amount(o_shift_amount), .o_pad_en(o_pad_en),
        .o_line_valid(o_line_valid), .o_bypass(o_bypass),
        .o_line_bits(o_line_bits), .o_word_count(o_word_count),
        .o_len_err(o_len_err), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef enum int {EV_STORE, EV_ERR, EV_LINE} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       shift;
        int       pad;
        int       bypass;
        int       bits;
        int       wc;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic push_store(input int shift, input int pad);
        ev_t e;
        e = '{kind: EV_STORE, shift: shift, pad: pad, bypass: 0, bits: 0, wc: 0};
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        ev_t e;
        e = '{kind: EV_ERR, shift: 0, pad: 0, bypass: 0, bits: 0, wc: 0};
        exp_q.push_back(e);
    endtask

    task automatic push_line(input int bypass, input int bits, input int wc);
        ev_t e;
        e = '{kind: EV_LINE, shift: 0, pad: 0, bypass: bypass, bits: bits, wc: wc};
        exp_q.push_back(e);
    endtask

    // Monitor: every store, error pulse and accepted line must match the queue head.
    initial begin
        ev_t e;
        forever begin
            @(negedge i_clk);
            if (i_reset !== 1'b1) begin
                if (o_store_en) begin
                    if (exp_q.size() == 0) check("store_unexpected", o_store_en, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("store_kind", EV_STORE, e.kind);
                        check("store_shift", o_shift_amount, e.shift);
                        check("store_pad", o_pad_en, e.pad);
                    end
                end
                if (o_len_err) begin
                    if (exp_q.size() == 0) check("err_unexpected", o_len_err, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("err_kind", EV_ERR, e.kind);
                    end
                end
                if (o_line_valid && i_out_ready) begin
                    if (exp_q.size() == 0) check("line_unexpected", o_line_valid, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("line_kind", EV_LINE, e.kind);
                        check("line_bypass", o_bypass, e.bypass);
                        check("line_bits", o_line_bits, e.bits);
                        check("line_word_count", o_word_count, e.wc);
                    end
                end
            end
        end
    end

    task automatic start_line();
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        check("busy_after_start", o_busy, 1);
    endtask

    task automatic send_len(input int len, input bit last);
        int n;
        n = 0;
        i_len_valid    = 1'b1;
        i_total_length = 7'(len);
        i_last         = last;
        @(negedge i_clk);
        while (!o_len_ready && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_len_ready) check("len_ready_timeout", o_len_ready, 1);
        @(posedge i_clk); #1;
        i_len_valid = 1'b0;
        i_last      = 1'b0;
    endtask

    task automatic finish_line();
        int n;
        n = 0;
        i_out_ready = 1'b1;
        @(negedge i_clk);
        while (!o_line_valid && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_line_valid) check("line_valid_timeout", o_line_valid, 1);
        @(posedge i_clk); #1;
        i_out_ready = 1'b0;
        check("idle_after_accept", o_busy, 0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {o_len_ready, o_store_en, o_shift_amount, o_pad_en, o_line_valid,
                     o_bypass, o_line_bits, o_word_count, o_len_err, o_busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (queue=%0d)", exp_q.size());
        $fatal(1);
    end

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0; i_len_valid = 1'b0; i_total_length = 7'd0;
        i_last = 1'b0; i_out_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_all_zero("reset_outputs");
        i_reset = 1'b0;
        @(posedge i_clk); #1;
        check("idle_no_ready", o_len_ready, 0);

        // Eight 16-bit chunks: exact fit, stores on chunks 4 and 8, no flush.
        start_line();
        for (int i = 1; i <= 8; i++) begin
            if (i == 4 || i == 8) push_store(64, 0);
            send_len(16, 1'b0);
        end
        // Hold OUTPUT while poking i_start / i_len_valid.
        for (int c = 0; c < 5; c++) begin
            i_start     = 1'b1;
            i_len_valid = c[0];
            @(negedge i_clk);
            check("hold_valid", o_line_valid, 1);
            check("hold_bits", o_line_bits, 128);
            check("hold_wc", o_word_count, 2);
            check("hold_bypass", o_bypass, 0);
            check("hold_no_ready", o_len_ready, 0);
            @(posedge i_clk); #1;
        end
        i_start = 1'b0; i_len_valid = 1'b0;
        push_line(0, 128, 2);
        finish_line();

        // 10+20+30 with early end: one padded flush of 4 bits.
        start_line();
        send_len(10, 1'b0);
        send_len(20, 1'b0);
        send_len(30, 1'b1);
        push_store(4, 1);
        push_line(0, 60, 1);
        finish_line();

        // 64,64 fill the budget; the next bit overflows and the rest drain.
        start_line();
        push_store(64, 0); send_len(64, 1'b0);
        push_store(64, 0); send_len(64, 1'b0);
        send_len(1, 1'b0);
        check("drain_busy", o_busy, 1);
        for (int i = 0; i < 5; i++) send_len(7, 1'b0);
        push_line(1, 0, 2);
        finish_line();

        // Reset mid-line, then 8x8 bits: a single store on the last chunk.
        start_line();
        send_len(20, 1'b0);
        send_len(20, 1'b0);
        i_reset = 1'b1;
        #1;
        check_all_zero("midline_reset_outputs");
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        @(posedge i_clk); #1;
        start_line();
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) push_store(64, 0);
            send_len(8, 1'b0);
        end
        push_line(0, 64, 1);
        finish_line();

        // Illegal first length, then an illegal length while draining.
        start_line();
        push_err(); send_len(65, 1'b0);
        send_len(10, 1'b0);
        send_len(10, 1'b0);
        push_err(); send_len(100, 1'b0);
        for (int i = 0; i < 4; i++) send_len(10, 1'b0);
        push_line(1, 0, 0);
        finish_line();

        // A single zero-length chunk ending the line: empty line, no flush.
        start_line();
        send_len(0, 1'b1);
        push_line(0, 0, 0);
        finish_line();

        repeat (2) @(posedge i_clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
